// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/breakpoint sequencer for the CPU status block
module cpu_run_ctrl #(
  parameter int STEP_W     = 16,
  parameter int SETTLE_CYC = 5,
  parameter int PC_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_stop,
  input  logic [STEP_W-1:0] step_num,
  input  logic              bp_en,
  input  logic [PC_W-1:0]   bp_addr,
  input  logic              wb_valid,
  input  logic [PC_W-1:0]   wb_pc,
  output logic              cpu_start,
  output logic              quit_cmd,
  output logic              cpu_running,
  output logic              busy,
  output logic              cmd_ack,
  output logic [1:0]        halt_cause,
  output logic [31:0]       retired_cnt
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC);

  typedef enum logic [1:0] {S_IDLE, S_SSET, S_RUN, S_QSET} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [STEP_W-1:0] step_rem_q, step_rem_d;
  logic              mode_step_q, mode_step_d;
  logic              start_q, start_d;
  logic              quit_q, quit_d;
  logic              ack_q, ack_d;
  logic [1:0]        cause_q, cause_d;
  logic [31:0]       cnt_q, cnt_d;

  logic bp_hit;
  logic step_done;

  // The breakpoint instruction itself retires; the halt takes effect after it.
  assign bp_hit    = wb_valid & bp_en & (wb_pc == bp_addr);
  assign step_done = mode_step_q & wb_valid & (step_rem_q == STEP_W'(1));

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    step_rem_d  = step_rem_q;
    mode_step_d = mode_step_q;
    start_d     = 1'b0;
    quit_d      = 1'b0;
    ack_d       = 1'b0;
    cause_d     = cause_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_stop) begin
          ack_d = 1'b1;
        end else if (cmd_step || cmd_run) begin
          start_d     = 1'b1;
          ack_d       = 1'b1;
          cause_d     = 2'd0;
          cnt_d       = '0;
          mode_step_d = cmd_step;
          if (cmd_step) begin
            step_rem_d = (step_num == '0) ? STEP_W'(1) : step_num;
          end else begin
            step_rem_d = '0;
          end
          settle_d = SETTLE_LD;
          state_d  = S_SSET;
        end
      end
      S_SSET: begin
        settle_d = settle_q - SW'(1);
        if (settle_q <= SW'(1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (wb_valid) begin
          cnt_d = cnt_q + 32'd1;
          if (mode_step_q) begin
            step_rem_d = step_rem_q - STEP_W'(1);
          end
        end
        if (bp_hit || step_done || cmd_stop) begin
          quit_d   = 1'b1;
          ack_d    = cmd_stop;
          settle_d = SETTLE_LD;
          state_d  = S_QSET;
          if (bp_hit) begin
            cause_d = 2'd2;
          end else if (step_done) begin
            cause_d = 2'd1;
          end else begin
            cause_d = 2'd3;
          end
        end
      end
      S_QSET: begin
        settle_d = settle_q - SW'(1);
        if (settle_q <= SW'(1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      settle_q    <= '0;
      step_rem_q  <= '0;
      mode_step_q <= 1'b0;
      start_q     <= 1'b0;
      quit_q      <= 1'b0;
      ack_q       <= 1'b0;
      cause_q     <= 2'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      step_rem_q  <= step_rem_d;
      mode_step_q <= mode_step_d;
      start_q     <= start_d;
      quit_q      <= quit_d;
      ack_q       <= ack_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cpu_start   = start_q;
  assign quit_cmd    = quit_q;
  assign cmd_ack     = ack_q;
  assign halt_cause  = cause_q;
  assign retired_cnt = cnt_q;
  assign cpu_running = (state_q == S_SSET) || (state_q == S_RUN);
  assign busy        = (state_q == S_SSET) || (state_q == S_QSET);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_run, cmd_step, cmd_stop;
  logic [15:0] step_num;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        cpu_start, quit_cmd, cpu_running, busy, cmd_ack;
  logic [1:0]  halt_cause;
  logic [31:0] retired_cnt;

  int tests  = 0;
  int errors = 0;

  // flags vector: {cpu_start, quit_cmd, cmd_ack, cpu_running, busy}
  logic [4:0] flags;
  assign flags = {cpu_start, quit_cmd, cmd_ack, cpu_running, busy};

  cpu_run_ctrl #(.STEP_W(16), .SETTLE_CYC(5), .PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_stop(cmd_stop),
    .step_num(step_num), .bp_en(bp_en), .bp_addr(bp_addr),
    .wb_valid(wb_valid), .wb_pc(wb_pc),
    .cpu_start(cpu_start), .quit_cmd(quit_cmd), .cpu_running(cpu_running),
    .busy(busy), .cmd_ack(cmd_ack), .halt_cause(halt_cause),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    cmd_run  = 1'b0;
    cmd_step = 1'b0;
    cmd_stop = 1'b0;
    wb_valid = 1'b0;
  endtask

  // Issue run/step from idle and advance into S_RUN (1 + 5 edges).
  task automatic go_run(input logic step, input logic [15:0] n);
    cmd_run  = ~step;
    cmd_step = step;
    step_num = n;
    tick();
    clear_pulses();
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic drain();
    clear_pulses();
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_pulses();
    step_num = '0; bp_en = 1'b0; bp_addr = '0; wb_pc = '0;
    tick(); tick();
    tests++;
    if (flags !== 5'b00000 || halt_cause !== 2'd0 || retired_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b cause=%0d cnt=%0d, expected 00000/0/0", flags, halt_cause, retired_cnt);
    end
    rst = 1'b0;
    cmd_stop = 1'b1;
    tick();
    clear_pulses();
    tests++;
    if (flags !== 5'b00100 || halt_cause !== 2'd0) begin
      errors++;
      $display("FAIL idle_stop_ack: flags=%b cause=%0d, expected 00100/0", flags, halt_cause);
    end
    tick();
    tests++;
    if (flags !== 5'b00000) begin
      errors++;
      $display("FAIL idle_stop_after: flags=%b, expected 00000", flags);
    end
  endtask

  task automatic test_step();
    cmd_step = 1'b1; step_num = 16'd3;
    tick();
    clear_pulses();
    tests++;
    if (flags !== 5'b10111 || halt_cause !== 2'd0 || retired_cnt !== 32'd0) begin
      errors++;
      $display("FAIL step_start: flags=%b cause=%0d cnt=%0d, expected 10111/0/0", flags, halt_cause, retired_cnt);
    end
    for (int i = 2; i <= 5; i++) begin
      tick();
      tests++;
      if (flags !== 5'b00011) begin
        errors++;
        $display("FAIL step_sset_%0d: flags=%b, expected 00011", i, flags);
      end
    end
    tick();
    tests++;
    if (flags !== 5'b00010) begin
      errors++;
      $display("FAIL step_enter_run: flags=%b, expected 00010", flags);
    end
    wb_valid = 1'b1; wb_pc = 32'h100;
    tick();
    wb_valid = 1'b0;
    tick();
    tests++;
    if (retired_cnt !== 32'd1 || quit_cmd !== 1'b0) begin
      errors++;
      $display("FAIL step_ret1: cnt=%0d quit=%b, expected 1/0", retired_cnt, quit_cmd);
    end
    wb_valid = 1'b1; wb_pc = 32'h104;
    tick();
    tests++;
    if (retired_cnt !== 32'd2 || quit_cmd !== 1'b0) begin
      errors++;
      $display("FAIL step_ret2: cnt=%0d quit=%b, expected 2/0", retired_cnt, quit_cmd);
    end
    wb_pc = 32'h108;
    tick();
    tests++;
    if (flags !== 5'b01001 || halt_cause !== 2'd1 || retired_cnt !== 32'd3) begin
      errors++;
      $display("FAIL step_done: flags=%b cause=%0d cnt=%0d, expected 01001/1/3", flags, halt_cause, retired_cnt);
    end
    wb_pc = 32'h10C;
    for (int i = 2; i <= 5; i++) begin
      tick();
      wb_valid = 1'b0;
      tests++;
      if (flags !== 5'b00001 || retired_cnt !== 32'd3) begin
        errors++;
        $display("FAIL step_qset_%0d: flags=%b cnt=%0d, expected 00001/3", i, flags, retired_cnt);
      end
    end
    tick();
    tests++;
    if (flags !== 5'b00000 || halt_cause !== 2'd1) begin
      errors++;
      $display("FAIL step_idle: flags=%b cause=%0d, expected 00000/1", flags, halt_cause);
    end
  endtask

  task automatic test_breakpoint();
    bp_en = 1'b1; bp_addr = 32'h40;
    cmd_run = 1'b1;
    tick();
    clear_pulses();
    tests++;
    if (flags !== 5'b10111 || halt_cause !== 2'd0 || retired_cnt !== 32'd0) begin
      errors++;
      $display("FAIL bp_start_clear: flags=%b cause=%0d cnt=%0d, expected 10111/0/0", flags, halt_cause, retired_cnt);
    end
    for (int i = 0; i < 5; i++) tick();
    wb_valid = 1'b1;
    wb_pc = 32'h38; tick();
    wb_pc = 32'h3C; tick();
    tests++;
    if (quit_cmd !== 1'b0 || retired_cnt !== 32'd2) begin
      errors++;
      $display("FAIL bp_pre: quit=%b cnt=%0d, expected 0/2", quit_cmd, retired_cnt);
    end
    wb_pc = 32'h40; tick();
    wb_valid = 1'b0;
    tests++;
    if (flags !== 5'b01001 || halt_cause !== 2'd2 || retired_cnt !== 32'd3) begin
      errors++;
      $display("FAIL bp_hit: flags=%b cause=%0d cnt=%0d, expected 01001/2/3", flags, halt_cause, retired_cnt);
    end
    drain();
    bp_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    bp_en = 1'b1; bp_addr = 32'h200;
    go_run(1'b1, 16'd1);
    wb_valid = 1'b1; wb_pc = 32'h200; cmd_stop = 1'b1;
    tick();
    clear_pulses();
    tests++;
    if (flags !== 5'b01101 || halt_cause !== 2'd2 || retired_cnt !== 32'd1) begin
      errors++;
      $display("FAIL simul_halt: flags=%b cause=%0d cnt=%0d, expected 01101/2/1", flags, halt_cause, retired_cnt);
    end
    tick();
    tests++;
    if (flags !== 5'b00001) begin
      errors++;
      $display("FAIL simul_single_pulse: flags=%b, expected 00001", flags);
    end
    drain();
    bp_en = 1'b0;
  endtask

  task automatic test_ignored();
    cmd_run = 1'b1;
    tick();
    tick();
    tests++;
    if (flags !== 5'b00011) begin
      errors++;
      $display("FAIL ign_run_sset: flags=%b, expected 00011", flags);
    end
    clear_pulses();
    for (int i = 0; i < 3; i++) tick();
    tick();
    tests++;
    if (flags !== 5'b00010) begin
      errors++;
      $display("FAIL ign_run_timing: flags=%b, expected 00010", flags);
    end
    cmd_step = 1'b1; step_num = 16'd2;
    tick();
    clear_pulses();
    tests++;
    if (flags !== 5'b00010) begin
      errors++;
      $display("FAIL ign_step_run: flags=%b, expected 00010", flags);
    end
    wb_valid = 1'b1; wb_pc = 32'h0;
    for (int i = 0; i < 3; i++) tick();
    wb_valid = 1'b0;
    tests++;
    if (flags !== 5'b00010 || retired_cnt !== 32'd3) begin
      errors++;
      $display("FAIL ign_free_mode: flags=%b cnt=%0d, expected 00010/3", flags, retired_cnt);
    end
    cmd_stop = 1'b1;
    tick();
    clear_pulses();
    tests++;
    if (flags !== 5'b01101 || halt_cause !== 2'd3) begin
      errors++;
      $display("FAIL user_stop: flags=%b cause=%0d, expected 01101/3", flags, halt_cause);
    end
    cmd_run = 1'b1;
    tick();
    clear_pulses();
    tests++;
    if (flags !== 5'b00001) begin
      errors++;
      $display("FAIL ign_run_qset: flags=%b, expected 00001", flags);
    end
    for (int i = 0; i < 3; i++) tick();
    tick();
    tests++;
    if (flags !== 5'b00000 || halt_cause !== 2'd3) begin
      errors++;
      $display("FAIL ign_qset_idle: flags=%b cause=%0d, expected 00000/3", flags, halt_cause);
    end
    go_run(1'b1, 16'd0);
    wb_valid = 1'b1;
    tick();
    clear_pulses();
    tests++;
    if (flags !== 5'b01001 || halt_cause !== 2'd1 || retired_cnt !== 32'd1) begin
      errors++;
      $display("FAIL step_zero: flags=%b cause=%0d cnt=%0d, expected 01001/1/1", flags, halt_cause, retired_cnt);
    end
    drain();
  endtask

  task automatic test_reset_mid_run();
    go_run(1'b0, 16'd0);
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    rst = 1'b1;
    tick();
    tests++;
    if (flags !== 5'b00000 || halt_cause !== 2'd0 || retired_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_run: flags=%b cause=%0d cnt=%0d, expected 00000/0/0", flags, halt_cause, retired_cnt);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (flags !== 5'b00000) begin
      errors++;
      $display("FAIL rst_mid_after: flags=%b, expected 00000", flags);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_breakpoint();
    test_simultaneous();
    test_ignored();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
